// File: rtl/vending_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vending_pkg
// Brief    : Shared error codes, FSM encoding and default coin values for the
//            vending money intake.
// Revision : 1.0
// ============================================================================
package vending_pkg;

    localparam logic [3:0] ERR_NONE     = 4'd0;
    localparam logic [3:0] ERR_INVALID  = 4'd1;
    localparam logic [3:0] ERR_OVERFLOW = 4'd2;
    localparam logic [3:0] ERR_CNT_SAT  = 4'd3;
    localparam logic [3:0] ERR_FUNDS    = 4'd4;

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_REFUND  = 1'b1
    } state_t;

    // Slice i holds the value of one-hot money_type bit i.
    localparam logic [63:0] DEFAULT_DENOM_VALUES = {16'd5000, 16'd2000, 16'd1000, 16'd500};

endpackage : vending_pkg
`default_nettype wire

// File: rtl/denom_counter.sv
`default_nettype none
// ============================================================================
// Module   : denom_counter
// Brief    : Saturating per-denomination coin counter with synchronous clear.
// Revision : 1.0
// ============================================================================
module denom_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [CNT_W-1:0] o_count,
    output logic             o_sat
);

    localparam logic [CNT_W-1:0] c_max = '1;

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clock) begin
        if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_sat) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;
    assign o_sat   = (r_count == c_max);

endmodule : denom_counter
`default_nettype wire

// File: rtl/money_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : money_accumulator
// Brief    : Coin intake with per-denomination inventory, running credit,
//            purchase deduction and refund handshake.
// Revision : 1.0
// ============================================================================
module money_accumulator
    import vending_pkg::*;
#(
    parameter int                              NUM_DENOM    = 4,
    parameter int                              CNT_W        = 8,
    parameter int                              TOTAL_W      = 16,
    parameter logic [NUM_DENOM*TOTAL_W-1:0]    DENOM_VALUES = DEFAULT_DENOM_VALUES
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       money_valid,
    input  logic [NUM_DENOM-1:0]       money_type,
    output logic                       money_ready,
    input  logic                       deduct_valid,
    input  logic [TOTAL_W-1:0]         deduct_amount,
    output logic                       deduct_ack,
    input  logic                       refund_req,
    output logic                       refund_valid,
    output logic [TOTAL_W-1:0]         refund_amount,
    input  logic                       refund_ack,
    output logic [TOTAL_W-1:0]         total,
    output logic [NUM_DENOM*CNT_W-1:0] counts,
    output logic [3:0]                 error
);

    state_t               r_state;
    state_t               w_state_next;
    logic [TOTAL_W-1:0]   r_total;
    logic [TOTAL_W-1:0]   r_refund_amount;
    logic                 r_deduct_ack;
    logic [3:0]           r_error;

    logic                 w_collect;
    logic                 w_onehot;
    logic [TOTAL_W-1:0]   w_coin_value;
    logic                 w_coin_try;
    logic                 w_deduct_try;
    logic                 w_deduct_ok;
    logic [TOTAL_W-1:0]   w_base;
    logic [TOTAL_W:0]     w_sum;
    logic                 w_overflow;
    logic                 w_coin_ok;
    logic [NUM_DENOM-1:0] w_sat;
    logic                 w_sat_hit;
    logic [TOTAL_W-1:0]   w_total_new;
    logic                 w_err_update;
    logic [3:0]           w_err_next;

    assign w_collect    = (r_state == ST_COLLECT);
    assign w_onehot     = $onehot(money_type);
    assign w_coin_try   = w_collect && money_valid;
    assign w_deduct_try = w_collect && deduct_valid;
    // Funds are checked against the registered credit, ignoring a same-cycle coin.
    assign w_deduct_ok  = w_deduct_try && (deduct_amount <= r_total);
    assign w_base       = w_deduct_ok ? (r_total - deduct_amount) : r_total;
    assign w_sum        = {1'b0, w_base} + {1'b0, w_coin_value};
    assign w_overflow   = w_sum[TOTAL_W];
    assign w_coin_ok    = w_coin_try && w_onehot && !w_overflow;
    assign w_sat_hit    = |(money_type & w_sat);
    assign w_total_new  = w_coin_ok ? w_sum[TOTAL_W-1:0] : w_base;

    always_comb begin
        w_coin_value = '0;
        for (int i = 0; i < NUM_DENOM; i++) begin
            if (money_type[i]) begin
                w_coin_value = w_coin_value | DENOM_VALUES[i*TOTAL_W +: TOTAL_W];
            end
        end
    end

    always_comb begin
        w_err_update = 1'b1;
        w_err_next   = ERR_NONE;
        if (w_deduct_try && !w_deduct_ok) begin
            w_err_next = ERR_FUNDS;
        end else if (w_coin_try && w_onehot && w_overflow) begin
            w_err_next = ERR_OVERFLOW;
        end else if (w_coin_ok && w_sat_hit) begin
            w_err_next = ERR_CNT_SAT;
        end else if (w_coin_try && !w_onehot) begin
            w_err_next = ERR_INVALID;
        end else if (!(w_coin_try || w_deduct_ok)) begin
            w_err_update = 1'b0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DENOM; gi++) begin : g_counter
            denom_counter #(
                .CNT_W (CNT_W)
            ) u_denom_counter (
                .clock    (clock),
                .i_clear  (reset),
                .i_enable (w_coin_ok && money_type[gi]),
                .o_count  (counts[gi*CNT_W +: CNT_W]),
                .o_sat    (w_sat[gi])
            );
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_COLLECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_COLLECT: if (refund_req && (w_total_new != '0)) w_state_next = ST_REFUND;
            ST_REFUND:  if (refund_ack) w_state_next = ST_COLLECT;
            default:    w_state_next = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_total         <= '0;
            r_refund_amount <= '0;
            r_deduct_ack    <= 1'b0;
            r_error         <= ERR_NONE;
        end else begin
            r_deduct_ack <= w_deduct_ok;
            if (w_err_update) begin
                r_error <= w_err_next;
            end
            if (w_collect) begin
                r_total <= w_total_new;
                if (w_state_next == ST_REFUND) begin
                    r_refund_amount <= w_total_new;
                end
            end else if (refund_ack) begin
                r_total         <= '0;
                r_refund_amount <= '0;
            end
        end
    end

    assign money_ready   = w_collect;
    assign refund_valid  = (r_state == ST_REFUND);
    assign refund_amount = r_refund_amount;
    assign deduct_ack    = r_deduct_ack;
    assign total         = r_total;
    assign error         = r_error;

endmodule : money_accumulator
`default_nettype wire

// File: tb/tb_money_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_money_accumulator
// Brief    : Directed self-checking bench; a CNT_W=2 copy covers saturation.
// Revision : 1.0
// ============================================================================
module tb_money_accumulator;

    logic        clock = 1'b0;
    logic        reset;
    logic        money_valid;
    logic [3:0]  money_type;
    logic        deduct_valid;
    logic [15:0] deduct_amount;
    logic        refund_req;
    logic        refund_ack;

    logic        money_ready,  money_ready2;
    logic        deduct_ack,   deduct_ack2;
    logic        refund_valid, refund_valid2;
    logic [15:0] refund_amount, refund_amount2;
    logic [15:0] total,        total2;
    logic [31:0] counts;
    logic [7:0]  counts2;
    logic [3:0]  error,        error2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    money_accumulator dut (
        .clock(clock), .reset(reset),
        .money_valid(money_valid), .money_type(money_type), .money_ready(money_ready),
        .deduct_valid(deduct_valid), .deduct_amount(deduct_amount), .deduct_ack(deduct_ack),
        .refund_req(refund_req), .refund_valid(refund_valid), .refund_amount(refund_amount),
        .refund_ack(refund_ack), .total(total), .counts(counts), .error(error)
    );

    money_accumulator #(.CNT_W(2)) dut2 (
        .clock(clock), .reset(reset),
        .money_valid(money_valid), .money_type(money_type), .money_ready(money_ready2),
        .deduct_valid(deduct_valid), .deduct_amount(deduct_amount), .deduct_ack(deduct_ack2),
        .refund_req(refund_req), .refund_valid(refund_valid2), .refund_amount(refund_amount2),
        .refund_ack(refund_ack), .total(total2), .counts(counts2), .error(error2)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        money_valid = 1'b0; money_type = 4'b0000;
        deduct_valid = 1'b0; deduct_amount = 16'd0;
        refund_req = 1'b0; refund_ack = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic coin(input logic [3:0] t);
        money_valid = 1'b1; money_type = t;
        tick();
        money_valid = 1'b0; money_type = 4'b0000;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        check("rst_total",   total, 0);
        check("rst_counts",  counts, 0);
        check("rst_error",   error, 0);
        check("rst_ready",   money_ready, 1);
        check("rst_rvalid",  refund_valid, 0);
        check("rst_ramount", refund_amount, 0);
        check("rst_dack",    deduct_ack, 0);

        // Each denomination once; update visible one cycle after handshake.
        coin(4'b0001); check("t1_500",  total, 500);
        coin(4'b0010); check("t1_1000", total, 1500);
        coin(4'b0100); check("t1_2000", total, 3500);
        coin(4'b1000); check("t1_5000", total, 8500);
        check("t1_counts", counts, 32'h01010101);
        check("t1_error",  error, 0);

        coin(4'b0011);
        check("t2_err_multi", error, 1);
        check("t2_total_a",   total, 8500);
        coin(4'b0000);
        check("t2_err_zero",  error, 1);
        check("t2_total_b",   total, 8500);
        check("t2_counts",    counts, 32'h01010101);

        do_reset();
        for (int i = 0; i < 13; i++) coin(4'b1000);
        check("t3_total65000", total, 65000);
        coin(4'b0010);
        check("t3_err_ovf",   error, 2);
        check("t3_total_ovf", total, 65000);
        check("t3_counts",    counts, 32'h0D000000);
        coin(4'b0001);
        check("t3_total65500", total, 65500);
        check("t3_err_clear",  error, 0);

        do_reset();
        coin(4'b0100); coin(4'b0010);
        check("t4_total3000", total, 3000);
        money_valid = 1'b1; money_type = 4'b0010;
        deduct_valid = 1'b1; deduct_amount = 16'd2500;
        tick();
        idle();
        check("t4_dack",  deduct_ack, 1);
        check("t4_total", total, 1500);
        check("t4_error", error, 0);
        deduct_valid = 1'b1; deduct_amount = 16'd2000;
        tick();
        idle();
        check("t4_err_funds", error, 4);
        check("t4_total_nf",  total, 1500);
        check("t4_no_ack",    deduct_ack, 0);

        refund_req = 1'b1; money_valid = 1'b1; money_type = 4'b0001;
        tick();
        idle();
        check("t5_rvalid",  refund_valid, 1);
        check("t5_ramount", refund_amount, 2000);
        check("t5_ready",   money_ready, 0);
        check("t5_total",   total, 2000);
        for (int i = 0; i < 3; i++) begin
            money_valid = 1'b1; money_type = 4'b0001;
            tick();
            check("t5_hold_rvalid", refund_valid, 1);
            check("t5_hold_total",  total, 2000);
        end
        idle();
        check("t5_counts_hold", counts, 32'h00010201);
        refund_ack = 1'b1;
        tick();
        idle();
        check("t5_ack_total",   total, 0);
        check("t5_ack_rvalid",  refund_valid, 0);
        check("t5_ack_ramount", refund_amount, 0);
        check("t5_ack_ready",   money_ready, 1);
        check("t5_counts_kept", counts, 32'h00010201);

        do_reset();
        coin(4'b0001); coin(4'b0001); coin(4'b0001);
        check("t6_err_3rd", error2, 0);
        coin(4'b0001);
        check("t6_count_sat", counts2, 8'h03);
        check("t6_err_sat",   error2, 3);
        check("t6_total",     total2, 2000);
        refund_req = 1'b1;
        tick();
        idle();
        check("t6_rvalid",  refund_valid2, 1);
        check("t6_ramount", refund_amount2, 2000);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_rst_total",   total2, 0);
        check("t6_rst_counts",  counts2, 0);
        check("t6_rst_error",   error2, 0);
        check("t6_rst_rvalid",  refund_valid2, 0);
        check("t6_rst_ramount", refund_amount2, 0);
        check("t6_rst_dack",    deduct_ack2, 0);
        check("t6_rst_ready",   money_ready2, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_money_accumulator
`default_nettype wire
